// File: rtl/sorted_store_pkg.sv
// Shared constants for the sorted key/data store writer:
// op codes, response status, FSM encoding, entry mux selects.
package sorted_store_pkg;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_UPDATED   = 2'b01;
  localparam logic [1:0] ST_NOT_FOUND = 2'b10;
  localparam logic [1:0] ST_FULL      = 2'b11;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SCAN       = 3'd1;
  localparam logic [2:0] S_SHIFT_UP   = 3'd2;
  localparam logic [2:0] S_SHIFT_DOWN = 3'd3;
  localparam logic [2:0] S_RESP       = 3'd4;

  // Entry next-value select
  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_LOWER = 2'd1;
  localparam logic [1:0] SEL_UPPER = 2'd2;
  localparam logic [1:0] SEL_NEW   = 2'd3;

  function automatic int entry_w(int kw, int dw);
    return kw + dw;
  endfunction

endpackage

// File: rtl/sorted_store_writer_ss_entry.sv
// One store entry: register with hold / from lower / from upper /
// new-word mux. Ports: clk, rst, sel, lower, upper, new_word, q.
module sorted_store_writer_ss_entry
  import sorted_store_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   sel,
  input  logic [W-1:0] lower,
  input  logic [W-1:0] upper,
  input  logic [W-1:0] new_word,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LOWER: q <= lower;
        SEL_UPPER: q <= upper;
        SEL_NEW:   q <= new_word;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sorted_store_writer.sv
// Write side of the sorted key/data store: insert/update/delete
// over valid/ready, order kept by one-entry-per-cycle shifts.
// Ports: clk, rst, req_*, resp_*, count, busy, rd_index, rd_word.
module sorted_store_writer
  import sorted_store_pkg::*;
#(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_op,
  input  logic [KEY_W-1:0]             req_key,
  input  logic [DATA_W-1:0]            req_data,
  output logic                         resp_valid,
  output logic [1:0]                   resp_status,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  input  logic [$clog2(DEPTH)-1:0]     rd_index,
  output logic [KEY_W+DATA_W-1:0]      rd_word
);

  localparam int EW = entry_w(KEY_W, DATA_W);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [2:0]        state;
  logic              op_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0]     idx;
  logic [CW-1:0]     p;
  logic [CW-1:0]     j;
  logic [CW-1:0]     cnt;
  logic [1:0]        status_q;

  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     scan_word;
  logic [KEY_W-1:0]  scan_key;
  logic [EW-1:0]     wr_word;
  logic [CW-1:0]     last;
  logic              at_end;
  logic              scan_done;
  logic              hit;
  logic              full;

  always_comb begin
    scan_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == CW'(i)) scan_word = mem[i];
    end
  end

  assign scan_key  = scan_word[EW-1 -: KEY_W];
  assign at_end    = (idx == cnt);
  assign scan_done = at_end || (scan_key >= key_q);
  assign hit       = !at_end && (scan_key == key_q);
  assign full      = (cnt == CW'(DEPTH));
  assign last      = cnt - 1'b1;

  // The vacated tail slot of a delete is cleared to keep the
  // "entries past count are zero" invariant.
  assign wr_word = (state == S_SHIFT_DOWN) ? '0 : {key_q, data_q};

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam logic [CW-1:0] GI = CW'(g);
    logic [EW-1:0] lower;
    logic [EW-1:0] upper;
    logic [1:0]    sel;

    if (g == 0) begin : g_lo0
      assign lower = '0;
    end else begin : g_lo
      assign lower = mem[g-1];
    end

    if (g == DEPTH-1) begin : g_up0
      assign upper = '0;
    end else begin : g_up
      assign upper = mem[g+1];
    end

    always_comb begin
      sel = SEL_HOLD;
      case (state)
        S_SCAN: begin
          if (scan_done && hit && op_q == OP_INSERT
              && idx == GI)
            sel = SEL_NEW;
        end
        S_SHIFT_UP: begin
          if (j == GI)
            sel = (j > p) ? SEL_LOWER : SEL_NEW;
        end
        S_SHIFT_DOWN: begin
          if (j == GI)
            sel = (j < last) ? SEL_UPPER : SEL_NEW;
        end
        default: sel = SEL_HOLD;
      endcase
    end

    sorted_store_writer_ss_entry #(.W(EW)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .lower    (lower),
      .upper    (upper),
      .new_word (wr_word),
      .q        (mem[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_INSERT;
      key_q    <= '0;
      data_q   <= '0;
      idx      <= '0;
      p        <= '0;
      j        <= '0;
      cnt      <= '0;
      status_q <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            key_q  <= req_key;
            data_q <= req_data;
            idx    <= '0;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_done) begin
            p <= idx;
            if (hit) begin
              if (op_q == OP_INSERT) begin
                status_q <= ST_UPDATED;
                state    <= S_RESP;
              end else begin
                j     <= idx;
                state <= S_SHIFT_DOWN;
              end
            end else if (op_q == OP_DELETE) begin
              status_q <= ST_NOT_FOUND;
              state    <= S_RESP;
            end else if (full) begin
              status_q <= ST_FULL;
              state    <= S_RESP;
            end else begin
              j     <= cnt;
              state <= S_SHIFT_UP;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_SHIFT_UP: begin
          if (j > p) begin
            j <= j - 1'b1;
          end else begin
            cnt      <= cnt + 1'b1;
            status_q <= ST_OK;
            state    <= S_RESP;
          end
        end
        S_SHIFT_DOWN: begin
          if (j < last) begin
            j <= j + 1'b1;
          end else begin
            cnt      <= cnt - 1'b1;
            status_q <= ST_OK;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_index == IW'(i)) rd_word = mem[i];
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign resp_valid  = (state == S_RESP);
  assign resp_status = status_q;
  assign count       = cnt;

endmodule

// File: tb/tb_sorted_store_writer.sv
// Scoreboard bench for sorted_store_writer at DEPTH=4,
// key/data 8 bits.
module tb_sorted_store_writer;

  localparam int KW = 8;
  localparam int DW = 8;
  localparam int D  = 4;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] UPD = 2'b01;
  localparam logic [1:0] NF  = 2'b10;
  localparam logic [1:0] FUL = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_op = 1'b0;
  logic [KW-1:0] req_key = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [2:0]    count;
  logic          busy;
  logic [1:0]    rd_index = '0;
  logic [15:0]   rd_word;

  sorted_store_writer #(
    .KEY_W(KW), .DATA_W(DW), .DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_key     (req_key),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_status (resp_status),
    .count       (count),
    .busy        (busy),
    .rd_index    (rd_index),
    .rd_word     (rd_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] st;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int resps  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      resps++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        check("status", 32'(resp_status), 32'(e.st));
        check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic op,
                      input logic [7:0] k,
                      input logic [7:0] d,
                      input logic [1:0] st,
                      input int lat);
    exp_t e;
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_key   = k;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.st  = st;
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
    drain();
  endtask

  task automatic rd(input int i, input logic [15:0] exp);
    rd_index = 2'(i);
    #1;
    check($sformatf("rd%0d", i), 32'(rd_word), 32'(exp));
  endtask

  int accepts;

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_resp", 32'(resp_valid), 0);
    check("rst_status", 32'(resp_status), 0);
    check("rst_ready", 32'(req_ready), 1);
    rd(0, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: first insert
    send(1'b0, 8'h20, 8'hAA, OK, 2);
    check("t1_count", 32'(count), 1);
    rd(0, 16'h20AA);
    rd(1, 16'h0000);

    // 2: fill the table
    send(1'b0, 8'h40, 8'h01, OK, 3);
    send(1'b0, 8'h10, 8'h02, OK, 4);
    send(1'b0, 8'h30, 8'h03, OK, 5);
    check("t2_count", 32'(count), 4);
    rd(0, 16'h1002);
    rd(1, 16'h20AA);
    rd(2, 16'h3003);
    rd(3, 16'h4001);

    // 3: full and update
    send(1'b0, 8'h50, 8'h09, FUL, 5);
    check("t3_count_full", 32'(count), 4);
    rd(0, 16'h1002);
    rd(1, 16'h20AA);
    rd(2, 16'h3003);
    rd(3, 16'h4001);
    send(1'b0, 8'h20, 8'hBB, UPD, 2);
    rd(1, 16'h20BB);
    check("t3_count_upd", 32'(count), 4);

    // 4: deletes
    send(1'b1, 8'h10, 8'h00, OK, 5);
    check("t4_count", 32'(count), 3);
    rd(0, 16'h20BB);
    rd(1, 16'h3003);
    rd(2, 16'h4001);
    rd(3, 16'h0000);
    send(1'b1, 8'h35, 8'h00, NF, 3);
    check("t4_count_nf", 32'(count), 3);

    // 5: reset during SHIFT_UP
    wait_ready();
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_key   = 8'h05;
    req_data  = 8'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_count", 32'(count), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_resp", 32'(resp_valid), 0);
    rd(0, 16'h0000);
    rd(1, 16'h0000);
    rd(2, 16'h0000);
    rd(3, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_ready", 32'(req_ready), 1);
    repeat (6) begin
      @(negedge clk); #1;
      check("t5_no_resp", 32'(resp_valid), 0);
    end

    // 6: request held high for 20 cycles
    accepts = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_key   = 8'h55;
    req_data  = 8'h77;
    for (int k = 0; k < 20; k++) begin
      if (busy) check("t6_ready_busy", 32'(req_ready), 0);
      if (req_ready) begin
        exp_t e;
        e.st  = (accepts == 0) ? OK : UPD;
        e.lat = (accepts == 0) ? 2 : 1;
        e.acc = cyc + 1;
        sb.push_back(e);
        accepts++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    check("t6_accepts", accepts, 7);
    check("t6_count", 32'(count), 1);
    rd(0, 16'h5577);
    rd(1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
